transmit: RTL and testbench
===========================

TRANSMIT -- requirements
Module: transmit

Interface
REQ-001 SHALL have a single clock `clk`; reset `rst` is asynchronous and active-high.
REQ-002 Ports SHALL be, in this order:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous reset, active-high.
- `b_en`  in  1  baud enable from `brg`, one `clk` wide, 16 pulses per bit (16x oversample).
- `i_iocs`  in  1  chip select.
- `i_iorw`  in  1  1 = read, 0 = write.
- `i_data`  in  8  byte to transmit.
- `o_tx`  out  1  serial line; idles high.
- `o_tbr`  out  1  transmit buffer ready; 1 = holding register empty.

Function
REQ-003 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-017), 1 stop bit (1).
REQ-004 Every frame bit SHALL be held on `o_tx` for exactly 16 `b_en` pulses.
- A 4-bit tick counter counts `b_en` pulses.
- The state advances on the 16th pulse.
REQ-005 A write SHALL be `i_iocs`=1 and `i_iorw`=0 on a `clk` rising edge.
- If `o_tbr`=1: load `i_data` into the 8-bit holding register and clear `o_tbr` on that edge.
- If `o_tbr`=0: ignore the write; holding contents are unchanged.
REQ-006 `i_iocs`=1 with `i_iorw`=1 SHALL have no effect on internal state.
REQ-007 The FSM SHALL have states IDLE, START, DATA, PARITY (only when compiled in) and STOP.
REQ-008 IDLE with the holding register full:
- Transfer the holding register to the shift register on the next `clk` edge.
- On that edge, go to START, drive `o_tx`=0 and set `o_tbr`=1.
- Write-accept to `o_tx` falling is exactly 1 `clk`.
REQ-009 START SHALL go to DATA after 16 ticks; bit index resets to 0.
REQ-010 DATA SHALL drive shift[0] and shift right every 16 ticks.
- A 3-bit index counts the bits.
- After bit 7 completes, go to PARITY if compiled in, else STOP.
REQ-011 At the end of STOP:
- If the holding register is full, go directly to START (back-to-back, zero idle cycles).
- Otherwise go to IDLE.
REQ-012 `o_tx` SHALL be registered and glitch-free, and SHALL be 1 in IDLE and STOP.
REQ-013 `b_en` in IDLE SHALL be ignored, and the tick counter SHALL hold at 0.
REQ-014 A write accepted while a frame is in progress SHALL NOT disturb that frame.
- This is double buffering: at most one byte in flight plus one held.

Reset
REQ-015 Asserting `rst` SHALL immediately force:
- `o_tx`=1, `o_tbr`=1;
- FSM to IDLE;
- tick counter, bit index, shift register and holding register to 0.
REQ-016 Reset mid-frame SHALL abort the frame with no partial completion; a pending held byte is discarded.

Configuration
REQ-017 Macro `TX_PARITY_EN`:
- Defined: PARITY state inserted after DATA, 16 ticks, driving even parity (XOR of the 8 data bits); frame = 11 bits, 176 `b_en` pulses.
- Undefined: no PARITY state; frame = 10 bits, 160 `b_en` pulses.

Verification (`brg` loaded 0x028B via DB high/low writes, 100 MHz `clk`)
REQ-018 Write 0xAB while idle:
- `o_tbr` low for 1 `clk`.
- `o_tx` low 1 `clk` after the write.
- Line sequence 0,1,1,0,1,0,1,0,1,1, each bit 16 `b_en` pulses, then idle high.
- The existing `recieve` bench, looped back, returns 0xAB with `o_rda`=1.
REQ-019 Write 0x55, then 0xC3 once `o_tbr` is high again:
- Frames are contiguous; no idle `clk` between the 0x55 stop bit and the 0xC3 start bit.
REQ-020 Write 0x11, then 0x22, then 0x33 while `o_tbr`=0:
- 0x33 is ignored; only 0x11 and 0x22 are transmitted.
REQ-021 Assert `rst` during data bit 3 of 0xF0:
- `o_tx`=1 and `o_tbr`=1 asynchronously, same cycle.
- No further line activity.
- A later write of 0x0F transmits a correct full frame.
REQ-022 Read cycle (`i_iocs`=1, `i_iorw`=1, `i_data`=0xFF) while idle:
- No frame; `o_tbr` stays 1.
REQ-023 With `TX_PARITY_EN`, write 0xAB:
- Parity bit = 1 after bit 7.
- Frame length 176 `b_en` pulses.

Source files
------------

// File: rtl/transmit.sv
// UART transmitter: 16x-oversampled framing with a one-byte holding register (double buffered).
// Optional even-parity bit after the data bits when TX_PARITY_EN is defined.
module transmit (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_en,
  input  logic       i_iocs,
  input  logic       i_iorw,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_tbr
);

  // state  | meaning
  // IDLE   | line high, waiting for a full holding register
  // START  | start bit (0)
  // DATA   | data bits, LSB first
  // PARITY | even parity of the 8 data bits (TX_PARITY_EN only)
  // STOP   | stop bit (1); chains straight into START if a byte is held
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t      r_state, w_state_n;
  logic [3:0]  r_tick, w_tick_n;
  logic [2:0]  r_idx, w_idx_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [7:0]  r_hold;
  logic        r_full;
  logic        r_tx, w_tx_n;
  logic        w_load;
  logic        w_wr;
  logic        w_bit_done;
`ifdef TX_PARITY_EN
  logic        r_par;
`endif

  assign w_wr       = i_iocs & ~i_iorw & ~r_full;
  assign w_bit_done = b_en & (r_tick == 4'hF);

  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_load    = 1'b0;
    if ((r_state != ST_IDLE) && b_en)
      w_tick_n = r_tick + 4'd1;
    case (r_state)
      ST_IDLE: begin
        w_tick_n = 4'd0;
        w_tx_n   = 1'b1;
        if (r_full) begin
          w_load    = 1'b1;
          w_shift_n = r_hold;
          w_state_n = ST_START;
          w_tx_n    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_done) begin
          w_state_n = ST_DATA;
          w_idx_n   = 3'd0;
          w_tx_n    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
`ifdef TX_PARITY_EN
            w_state_n = ST_PARITY;
            w_tx_n    = r_par;
`else
            w_state_n = ST_STOP;
            w_tx_n    = 1'b1;
`endif
          end else begin
            w_idx_n = r_idx + 3'd1;
            w_tx_n  = r_shift[1];
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_done) begin
          w_state_n = ST_STOP;
          w_tx_n    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_done) begin
          if (r_full) begin
            w_load    = 1'b1;
            w_shift_n = r_hold;
            w_state_n = ST_START;
            w_tx_n    = 1'b0;
          end else begin
            w_state_n = ST_IDLE;
            w_tx_n    = 1'b1;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tick  <= 4'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_hold  <= 8'd0;
      r_full  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      // load and write-accept are exclusive: one needs a full buffer, the other an empty one
      if (w_load)
        r_full <= 1'b0;
      else if (w_wr) begin
        r_full <= 1'b1;
        r_hold <= i_data;
      end
    end
  end

`ifdef TX_PARITY_EN
  // parity captured at load since the shift register is consumed during DATA
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_par <= 1'b0;
    else if (w_load)
      r_par <= ^r_hold;
  end
`endif

  assign o_tx  = r_tx;
  assign o_tbr = ~r_full;

endmodule

// File: tb/tb_transmit.sv
// Self-checking bench for transmit: randomized b_en spacing and data, line decoded per b_en pulse
// and compared against frames built from the byte stream the bench wrote.
module tb_transmit;

  logic       clk;
  logic       rst;
  logic       b_en;
  logic       i_iocs;
  logic       i_iorw;
  logic [7:0] i_data;
  logic       o_tx;
  logic       o_tbr;

  int total = 0;
  int bad   = 0;

`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct packed {
    logic [10:0] bits;
    logic        uni;
  } frame_t;

  frame_t rx_q[$];
  logic   gap_q[$];

  logic [10:0] m_bits;
  int          m_cnt = 0;
  bit          m_act = 0;
  logic        m_uni;
  bit          m_gap_pend = 0;

  transmit dut (
    .clk   (clk),
    .rst   (rst),
    .b_en  (b_en),
    .i_iocs(i_iocs),
    .i_iorw(i_iorw),
    .i_data(i_data),
    .o_tx  (o_tx),
    .o_tbr (o_tbr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // b_en: one clk wide, 1..3 clks low between pulses
  initial begin
    int gap;
    gap  = 2;
    b_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gap == 0) begin
        b_en = 1'b1;
        gap  = int'($urandom_range(1, 3));
      end else begin
        b_en = 1'b0;
        gap  = gap - 1;
      end
    end
  end

  // line monitor: each counted b_en pulse pairs with the line value just before its edge
  initial begin
    int bi;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act      = 0;
        m_cnt      = 0;
        m_gap_pend = 0;
      end else begin
        if (m_gap_pend) begin
          gap_q.push_back(o_tx);
          m_gap_pend = 0;
        end
        if (b_en) begin
          if (!m_act) begin
            if (o_tx === 1'b0) begin
              m_act  = 1;
              m_cnt  = 1;
              m_bits = '0;
              m_uni  = 1'b1;
            end
          end else begin
            bi = m_cnt / 16;
            if (m_cnt % 16 == 0)
              m_bits[bi] = o_tx;
            else if (m_bits[bi] !== o_tx)
              m_uni = 1'b0;
            m_cnt = m_cnt + 1;
            if (m_cnt == NB * 16) begin
              rx_q.push_back({m_bits, m_uni});
              m_act      = 0;
              m_gap_pend = 1;
            end
          end
        end
      end
    end
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f      = '0;
    f[8:1] = d;
`ifdef TX_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [7:0] d);
    i_iocs = 1'b1;
    i_iorw = 1'b0;
    i_data = d;
    @(posedge clk);
    #1;
    i_iocs = 1'b0;
    i_data = 8'h00;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (o_tx !== 1'b1) lows++;
    end
  endtask

  task automatic test_reset;
    int lows;
    rst = 1'b1;
    tick(3);
    total++;
    if (o_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", o_tx); end
    total++;
    if (o_tbr !== 1'b1) begin bad++; $display("FAIL reset_tbr got=%b want=1", o_tbr); end
    rst = 1'b0;
    count_lows(100, lows);
    total++;
    if (lows != 0) begin bad++; $display("FAIL idle_line low_cycles=%0d want=0", lows); end
    total++;
    if (rx_q.size() != 0) begin bad++; $display("FAIL idle_frames got=%0d want=0", rx_q.size()); end
  endtask

  task automatic test_single;
    bit     ok;
    frame_t f;
    logic   g;
    rx_q.delete();
    gap_q.delete();
    do_write(8'hAB);
    total++;
    if (o_tbr !== 1'b0) begin bad++; $display("FAIL single_tbr_low got=%b want=0", o_tbr); end
    total++;
    if (o_tx !== 1'b1) begin bad++; $display("FAIL single_tx_still_high got=%b want=1", o_tx); end
    tick(1);
    total++;
    if (o_tx !== 1'b0) begin bad++; $display("FAIL single_tx_fall got=%b want=0", o_tx); end
    total++;
    if (o_tbr !== 1'b1) begin bad++; $display("FAIL single_tbr_back got=%b want=1", o_tbr); end
    wait_frames(1, 1000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout frames=%0d want=1", rx_q.size()); end
    if (ok) begin
      f = rx_q.pop_front();
      total++;
      if (f.bits !== exp_frame(8'hAB) || f.uni !== 1'b1) begin
        bad++;
        $display("FAIL single_frame got=%b uni=%b want=%b", f.bits, f.uni, exp_frame(8'hAB));
      end
    end
    tick(2);
    g = (gap_q.size() > 0) ? gap_q.pop_front() : 1'bx;
    total++;
    if (g !== 1'b1) begin bad++; $display("FAIL single_idle_after got=%b want=1", g); end
  endtask

  task automatic test_back_to_back;
    bit     ok;
    frame_t f;
    logic   g;
    logic [7:0] exp_d[2];
    exp_d[0] = 8'h55;
    exp_d[1] = 8'hC3;
    rx_q.delete();
    gap_q.delete();
    do_write(8'h55);
    tick(1);
    do_write(8'hC3);
    total++;
    if (o_tbr !== 1'b0) begin bad++; $display("FAIL b2b_held_tbr got=%b want=0", o_tbr); end
    wait_frames(2, 2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_timeout frames=%0d want=2", rx_q.size()); end
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        f = rx_q.pop_front();
        total++;
        if (f.bits !== exp_frame(exp_d[k]) || f.uni !== 1'b1) begin
          bad++;
          $display("FAIL b2b_frame%0d got=%b uni=%b want=%b", k, f.bits, f.uni, exp_frame(exp_d[k]));
        end
      end
    end
    tick(2);
    for (int k = 0; k < 2; k++) begin
      g = (gap_q.size() > 0) ? gap_q.pop_front() : 1'bx;
      total++;
      if (g !== (k == 0 ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL b2b_gap%0d line_after_stop got=%b want=%b", k, g, (k == 0 ? 1'b0 : 1'b1));
      end
    end
  endtask

  task automatic test_overrun;
    bit     ok;
    frame_t f;
    logic [7:0] exp_d[2];
    exp_d[0] = 8'h11;
    exp_d[1] = 8'h22;
    rx_q.delete();
    gap_q.delete();
    do_write(8'h11);
    tick(1);
    do_write(8'h22);
    do_write(8'h33);
    total++;
    if (o_tbr !== 1'b0) begin bad++; $display("FAIL overrun_tbr got=%b want=0", o_tbr); end
    wait_frames(2, 2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL overrun_timeout frames=%0d want=2", rx_q.size()); end
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        f = rx_q.pop_front();
        total++;
        if (f.bits !== exp_frame(exp_d[k]) || f.uni !== 1'b1) begin
          bad++;
          $display("FAIL overrun_frame%0d got=%b uni=%b want=%b", k, f.bits, f.uni, exp_frame(exp_d[k]));
        end
      end
    end
    tick(800);
    total++;
    if (rx_q.size() != 0) begin bad++; $display("FAIL overrun_extra frames=%0d want=0", rx_q.size()); end
    total++;
    if (o_tbr !== 1'b1) begin bad++; $display("FAIL overrun_end_tbr got=%b want=1", o_tbr); end
  endtask

  task automatic test_reset_midframe;
    bit     ok;
    int     c;
    int     lows;
    frame_t f;
    logic   g;
    rx_q.delete();
    gap_q.delete();
    do_write(8'hF0);
    tick(1);
    do_write(8'hAA);
    c = 0;
    while (!(m_act && m_cnt >= 68) && c < 1500) begin
      tick(1);
      c++;
    end
    total++;
    if (c >= 1500) begin bad++; $display("FAIL rstmid_reach_bit3 waited=%0d limit=1500", c); end
    total++;
    if (o_tx !== 1'b0) begin bad++; $display("FAIL rstmid_bit3_level got=%b want=0", o_tx); end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (o_tx !== 1'b1) begin bad++; $display("FAIL rstmid_async_tx got=%b want=1", o_tx); end
    total++;
    if (o_tbr !== 1'b1) begin bad++; $display("FAIL rstmid_async_tbr got=%b want=1", o_tbr); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rx_q.delete();
    gap_q.delete();
    count_lows(800, lows);
    total++;
    if (lows != 0) begin bad++; $display("FAIL rstmid_quiet low_cycles=%0d want=0", lows); end
    total++;
    if (rx_q.size() != 0) begin bad++; $display("FAIL rstmid_no_frame frames=%0d want=0", rx_q.size()); end
    do_write(8'h0F);
    wait_frames(1, 1000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_after_timeout frames=%0d want=1", rx_q.size()); end
    if (ok) begin
      f = rx_q.pop_front();
      total++;
      if (f.bits !== exp_frame(8'h0F) || f.uni !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_after_frame got=%b uni=%b want=%b", f.bits, f.uni, exp_frame(8'h0F));
      end
    end
    tick(2);
    g = (gap_q.size() > 0) ? gap_q.pop_front() : 1'bx;
    total++;
    if (g !== 1'b1) begin bad++; $display("FAIL rstmid_after_idle got=%b want=1", g); end
  endtask

  task automatic test_read;
    int lows;
    rx_q.delete();
    gap_q.delete();
    i_iocs = 1'b1;
    i_iorw = 1'b1;
    i_data = 8'hFF;
    @(posedge clk);
    #1;
    i_iocs = 1'b0;
    i_iorw = 1'b0;
    i_data = 8'h00;
    total++;
    if (o_tbr !== 1'b1) begin bad++; $display("FAIL read_tbr got=%b want=1", o_tbr); end
    count_lows(400, lows);
    total++;
    if (lows != 0) begin bad++; $display("FAIL read_line low_cycles=%0d want=0", lows); end
    total++;
    if (rx_q.size() != 0) begin bad++; $display("FAIL read_frames got=%0d want=0", rx_q.size()); end
  endtask

  task automatic test_random;
    bit         ok;
    frame_t     f;
    logic       g;
    int         n;
    logic [7:0] exp_d[2];
    for (int it = 0; it < 6; it++) begin
      rx_q.delete();
      gap_q.delete();
      n        = int'($urandom_range(1, 2));
      exp_d[0] = 8'($urandom);
      exp_d[1] = 8'($urandom);
      do_write(exp_d[0]);
      if (n == 2) begin
        tick(int'($urandom_range(1, 20)));
        do_write(exp_d[1]);
        if ($urandom_range(0, 1) == 1) do_write(8'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        i_iocs = 1'b1;
        i_iorw = 1'b1;
        i_data = 8'($urandom);
        @(posedge clk);
        #1;
        i_iocs = 1'b0;
        i_iorw = 1'b0;
      end
      wait_frames(n, 2000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand%0d_timeout frames=%0d want=%0d", it, rx_q.size(), n); end
      if (ok) begin
        for (int k = 0; k < n; k++) begin
          f = rx_q.pop_front();
          total++;
          if (f.bits !== exp_frame(exp_d[k]) || f.uni !== 1'b1) begin
            bad++;
            $display("FAIL rand%0d_frame%0d got=%b uni=%b want=%b", it, k, f.bits, f.uni, exp_frame(exp_d[k]));
          end
        end
      end
      tick(2);
      for (int k = 0; k < n; k++) begin
        g = (gap_q.size() > 0) ? gap_q.pop_front() : 1'bx;
        total++;
        if (g !== ((k == n - 1) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL rand%0d_gap%0d got=%b want=%b", it, k, g, ((k == n - 1) ? 1'b1 : 1'b0));
        end
      end
      tick(int'($urandom_range(0, 50)));
    end
  endtask

  initial begin
    rst    = 1'b1;
    i_iocs = 1'b0;
    i_iorw = 1'b0;
    i_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    test_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog sim_time=%0t limit=3000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
